// File: rtl/sc_phase_gen.sv
// sc_phase_gen: two-phase non-overlapping clock generator for the
// switched-capacitor filter. One period is P1, GAP12, P2, GAP21, taking
// 2*half_period + 2*dead_time clock cycles.
//
// Handshake/config: cfg_load is a one-cycle strobe that captures
// half_period/dead_time into shadow registers in any state. The active
// copies follow the shadows only in IDLE and on GAP21->P1, so a period
// never changes length partway through. A cfg_load on the same edge as
// a period start is written through to that period.
//
// Optional feature: define SC_PHASE_GEN_OVERLAP_GUARD_EN to add a final
// gate that blanks both phases whenever both decodes are high, and to
// record that event in the sticky overlap_err flag.
module sc_phase_gen #(
    parameter int DIV_W  = 8,
    parameter int DEAD_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cfg_load,
    input  logic [DIV_W-1:0]  half_period,
    input  logic [DEAD_W-1:0] dead_time,
    output logic              phi1,
    output logic              phi2,
    output logic              sample_valid,
    output logic              busy,
    output logic              overlap_err
);

    localparam int CNT_W = (DIV_W > DEAD_W) ? DIV_W : DEAD_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        P1    = 3'd1,
        GAP12 = 3'd2,
        P2    = 3'd3,
        GAP21 = 3'd4
    } state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [DIV_W-1:0]  hp_s, hp_a, hp_a_nx, hp_src, hp_eff;
    logic [DEAD_W-1:0] dt_s, dt_a, dt_a_nx, dt_src, dt_eff;
    logic              p1_dec, p2_dec, sv_dec;
    logic              phi1_d, phi2_d;

    // Value a new period would use: shadow, or the incoming value on a
    // same-cycle cfg_load (write-through), with zero clamped to one.
    always_comb begin
        hp_src = cfg_load ? half_period : hp_s;
        dt_src = cfg_load ? dead_time : dt_s;
        hp_eff = (hp_src == '0) ? DIV_W'(1) : hp_src;
        dt_eff = (dt_src == '0) ? DEAD_W'(1) : dt_src;
    end

    // Next-state and down-counter decode; the counter holds the cycles
    // remaining in the current state minus one.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        hp_a_nx  = hp_a;
        dt_a_nx  = dt_a;
        case (state)
            IDLE: begin
                hp_a_nx = hp_eff;
                dt_a_nx = dt_eff;
                cnt_nx  = '0;
                if (en) begin
                    state_nx = P1;
                    cnt_nx   = CNT_W'(hp_eff - DIV_W'(1));
                end
            end
            P1: begin
                if (cnt == '0) begin
                    state_nx = GAP12;
                    cnt_nx   = CNT_W'(dt_a - DEAD_W'(1));
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            GAP12: begin
                if (cnt == '0) begin
                    state_nx = P2;
                    cnt_nx   = CNT_W'(hp_a - DIV_W'(1));
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            P2: begin
                if (cnt == '0) begin
                    state_nx = GAP21;
                    cnt_nx   = CNT_W'(dt_a - DEAD_W'(1));
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            GAP21: begin
                if (cnt == '0) begin
                    if (en) begin
                        state_nx = P1;
                        hp_a_nx  = hp_eff;
                        dt_a_nx  = dt_eff;
                        cnt_nx   = CNT_W'(hp_eff - DIV_W'(1));
                    end else begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Output decodes taken from the next state so the flops below are
    // glitch-free copies of the phase that is about to begin.
    assign p1_dec = (state_nx == P1);
    assign p2_dec = (state_nx == P2);
    assign sv_dec = (state == P2) && (state_nx == GAP21);

`ifdef SC_PHASE_GEN_OVERLAP_GUARD_EN
    logic both_dec;
    assign both_dec = p1_dec & p2_dec;
    assign phi1_d   = p1_dec & ~both_dec;
    assign phi2_d   = p2_dec & ~both_dec;

    // Sticky record of any cycle where both phases were decoded high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) overlap_err <= 1'b0;
        else if (both_dec) overlap_err <= 1'b1;
    end
`else
    assign phi1_d      = p1_dec;
    assign phi2_d      = p2_dec;
    assign overlap_err = 1'b0;
`endif

    // FSM, counter, shadow/active configuration and registered phases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            hp_s         <= DIV_W'(1);
            dt_s         <= DEAD_W'(1);
            hp_a         <= DIV_W'(1);
            dt_a         <= DEAD_W'(1);
            phi1         <= 1'b0;
            phi2         <= 1'b0;
            sample_valid <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            hp_a         <= hp_a_nx;
            dt_a         <= dt_a_nx;
            phi1         <= phi1_d;
            phi2         <= phi2_d;
            sample_valid <= sv_dec;
            if (cfg_load) begin
                hp_s <= half_period;
                dt_s <= dead_time;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_sc_phase_gen.sv
// Testbench for sc_phase_gen. A period-level reference model expands each
// started period into a queue of expected per-cycle outputs
// {phi1, phi2, sample_valid, busy}; a new period starts whenever the queue
// is empty and en is sampled high.
module tb_sc_phase_gen;

    localparam int DIV_W  = 8;
    localparam int DEAD_W = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              en;
    logic              cfg_load;
    logic [DIV_W-1:0]  half_period;
    logic [DEAD_W-1:0] dead_time;
    logic              phi1, phi2, sample_valid, busy, overlap_err;

    sc_phase_gen #(.DIV_W(DIV_W), .DEAD_W(DEAD_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .cfg_load     (cfg_load),
        .half_period  (half_period),
        .dead_time    (dead_time),
        .phi1         (phi1),
        .phi2         (phi2),
        .sample_valid (sample_valid),
        .busy         (busy),
        .overlap_err  (overlap_err)
    );

    // ---------------- checking ----------------
    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // ---------------- reference model / scoreboard ----------------
    logic [3:0] exp_q[$];          // {phi1, phi2, sample_valid, busy}
    logic [3:0] exp_cur = 4'b0000;
    logic       exp_ovl = 1'b0;
    int         m_hp    = 1;
    int         m_dt    = 1;

    function automatic void model_reset();
        exp_q.delete();
        exp_cur = 4'b0000;
        exp_ovl = 1'b0;
        m_hp    = 1;
        m_dt    = 1;
    endfunction

    function automatic void model_start(input int hp, input int dt);
        for (int i = 0; i < hp; i++) exp_q.push_back(4'b1001);
        for (int i = 0; i < dt; i++) exp_q.push_back(4'b0001);
        for (int i = 0; i < hp; i++) exp_q.push_back(4'b0101);
        exp_q.push_back(4'b0011);
        for (int i = 1; i < dt; i++) exp_q.push_back(4'b0001);
    endfunction

    // Applies the inputs about to be sampled at the next rising edge.
    function automatic void model_edge();
        if (cfg_load) begin
            m_hp = int'(half_period);
            m_dt = int'(dead_time);
        end
        if (exp_q.size() == 0 && en)
            model_start((m_hp == 0) ? 1 : m_hp, (m_dt == 0) ? 1 : m_dt);
        exp_cur = (exp_q.size() != 0) ? exp_q.pop_front() : 4'b0000;
    endfunction

    task automatic compare_all();
        check("phi1", phi1, exp_cur[3]);
        check("phi2", phi2, exp_cur[2]);
        check("sample_valid", sample_valid, exp_cur[1]);
        check("busy", busy, exp_cur[0]);
        check("overlap_err", overlap_err, exp_ovl);
        check("no_overlap", phi1 & phi2, 1'b0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic load_cfg(input int hp, input int dt);
        half_period = DIV_W'(hp);
        dead_time   = DEAD_W'(dt);
        cfg_load    = 1'b1;
        step();
        cfg_load    = 1'b0;
    endtask

    task automatic wait_phase(input int bit_idx, input int budget);
        int i;
        i = 0;
        while (!exp_cur[bit_idx] && i < budget) begin
            step();
            i++;
        end
        check("wait_phase_reached", exp_cur[bit_idx], 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst         = 1'b1;
        en          = 1'b0;
        cfg_load    = 1'b0;
        half_period = '0;
        dead_time   = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        compare_all();
        rst = 1'b0;
        repeat (3) step();

        // Nominal 3/2 run over 100 periods.
        load_cfg(3, 2);
        en = 1'b1;
        repeat (1000) step();

        // Graceful stop: drop en during P1.
        wait_phase(3, 20);
        en = 1'b0;
        repeat (30) step();

        // Zero clamp: 0/0 behaves as 1/1.
        load_cfg(0, 0);
        en = 1'b1;
        repeat (40) step();
        en = 1'b0;
        repeat (10) step();

        // Mid-run reconfiguration during P2.
        load_cfg(3, 2);
        en = 1'b1;
        repeat (12) step();
        wait_phase(2, 20);
        load_cfg(6, 1);
        repeat (60) step();

        // Randomized traffic, including write-through and start/stop.
        repeat (2000) begin
            en          = ($urandom_range(0, 9) < 8);
            cfg_load    = ($urandom_range(0, 14) == 0);
            half_period = DIV_W'($urandom_range(0, 5));
            dead_time   = DEAD_W'($urandom_range(0, 3));
            step();
        end
        cfg_load = 1'b0;

        // Asynchronous reset in the middle of P2 with half_period=5.
        en = 1'b0;
        repeat (25) step();
        load_cfg(5, 2);
        en = 1'b1;
        wait_phase(2, 20);
        step();
        #2 rst = 1'b1;
        #1;
        check("rst_phi1", phi1, 1'b0);
        check("rst_phi2", phi2, 1'b0);
        check("rst_sample_valid", sample_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_overlap_err", overlap_err, 1'b0);
        model_reset();
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) step();
        en = 1'b1;
        repeat (30) step();

`ifdef SC_PHASE_GEN_OVERLAP_GUARD_EN
        // Inject both decodes high for one edge.
        model_edge();
        force dut.p1_dec = 1'b1;
        force dut.p2_dec = 1'b1;
        @(posedge clk);
        #1;
        release dut.p1_dec;
        release dut.p2_dec;
        @(negedge clk);
        check("guard_phi1", phi1, 1'b0);
        check("guard_phi2", phi2, 1'b0);
        check("guard_busy", busy, exp_cur[0]);
        check("guard_overlap_err", overlap_err, 1'b1);
        exp_ovl = 1'b1;
        repeat (20) step();
        rst = 1'b1;
        #1;
        check("guard_rst_clear", overlap_err, 1'b0);
        model_reset();
        en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) step();
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
